// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the register-file write port
// Grants one valid/ready writeback per cycle and registers it onto A3/WD3/WE3 or the PC-load port.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int PC_REG = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic                 flush,
   input  logic                 req0_valid,
   input  logic [ADDR_W-1:0]    req0_addr,
   input  logic [DATA_W-1:0]    req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [ADDR_W-1:0]    req1_addr,
   input  logic [DATA_W-1:0]    req1_data,
   output logic                 req1_ready,
   output logic                 WE3,
   output logic [ADDR_W-1:0]    A3,
   output logic [DATA_W-1:0]    WD3,
   output logic                 pc_we,
   output logic [DATA_W-1:0]    pc_wdata,
   output logic [(2**ADDR_W)-1:0] pending_mask
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

   logic                rr_ptr;
   logic                we_q;
   logic                pc_we_q;
   logic [ADDR_W-1:0]   a3_q;
   logic [DATA_W-1:0]   wd3_q;
   logic [DATA_W-1:0]   pc_wdata_q;

   logic                blocked;
   logic                both;
   logic                gnt0;
   logic                gnt1;
   logic                fire;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_is_pc;

   function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
      logic [NREG-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

   // Same-address conflicts always go to req0 so the younger value is written last.
   always_comb begin
      blocked   = rst | flush | hold;
      both      = req0_valid & req1_valid;
      gnt0      = ~blocked & req0_valid &
                  (~req1_valid | (req0_addr == req1_addr) | ~rr_ptr);
      gnt1      = ~blocked & req1_valid & ~gnt0;
      fire      = gnt0 | gnt1;
      sel_addr  = gnt1 ? req1_addr : req0_addr;
      sel_data  = gnt1 ? req1_data : req0_data;
      sel_is_pc = (sel_addr == PC_ADDR);
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= 1'b0;
         we_q       <= 1'b0;
         pc_we_q    <= 1'b0;
         a3_q       <= '0;
         wd3_q      <= '0;
         pc_wdata_q <= '0;
      end else begin
         we_q    <= fire & ~sel_is_pc;
         pc_we_q <= fire & sel_is_pc;
         if (fire && !sel_is_pc) begin
            a3_q  <= sel_addr;
            wd3_q <= sel_data;
         end
         if (fire && sel_is_pc) begin
            pc_wdata_q <= sel_data;
         end
         // Pointer moves to the loser, only when both were competing.
         if (fire && both) begin
            rr_ptr <= gnt0;
         end
      end
   end

   // flush kills the write sitting in the output stage during the same cycle.
   assign WE3      = we_q & ~flush & ~rst;
   assign pc_we    = pc_we_q & ~flush & ~rst;
   assign A3       = a3_q;
   assign WD3      = wd3_q;
   assign pc_wdata = pc_wdata_q;

   always_comb begin
      pending_mask = '0;
      if (!rst) begin
         if (WE3)        pending_mask = pending_mask | onehot(A3);
         if (pc_we)      pending_mask = pending_mask | onehot(PC_ADDR);
         if (req0_valid) pending_mask = pending_mask | onehot(req0_addr);
         if (req1_valid) pending_mask = pending_mask | onehot(req1_addr);
      end
   end

endmodule
